// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared types and defaults for the CPU memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int c_MAX_DATA_STREAK = 4;
  localparam int c_STREAK_W        = 4;

  typedef enum logic [1:0] {
    RSP_NONE    = 2'd0,
    RSP_FETCH   = 2'd1,
    RSP_DATA_RD = 2'd2,
    RSP_DATA_WR = 2'd3
  } rspState_t;

  function automatic rspState_t nextRspState(input logic fetchGnt,
                                             input logic dataGnt,
                                             input logic dataWrite);
    rspState_t s;
    s = RSP_NONE;
    if (fetchGnt)     s = RSP_FETCH;
    else if (dataGnt) s = dataWrite ? RSP_DATA_WR : RSP_DATA_RD;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Fetch/data arbiter onto one single-port synchronous memory.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = c_MAX_DATA_STREAK
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_FetchReq,
  input  logic [ADDR_W-1:0] i_FetchAddr,
  output logic              o_FetchGnt,
  output logic              o_FetchRspValid,
  output logic [DATA_W-1:0] o_FetchRspData,
  input  logic              i_DataReq,
  input  logic              i_DataWrite,
  input  logic [ADDR_W-1:0] i_DataAddr,
  input  logic [DATA_W-1:0] i_DataWdata,
  output logic              o_DataGnt,
  output logic              o_DataRspValid,
  output logic [DATA_W-1:0] o_DataRspData,
  output logic              o_MemWriteEnable,
  output logic [ADDR_W-1:0] o_MemAddress,
  output logic [DATA_W-1:0] o_MemDataIn,
  input  logic [DATA_W-1:0] i_MemDataOut
);

  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DATA_STREAK);

  rspState_t              r_rspState;
  logic [c_STREAK_W-1:0]  r_streak;
  logic                   w_fetchWins;
  logic                   w_fetchGnt;
  logic                   w_dataGnt;

  // Data normally wins; a pending fetch wins once the data streak saturates.
  assign w_fetchWins = i_FetchReq && (!i_DataReq || (r_streak == c_STREAK_MAX));
  assign w_fetchGnt  = i_Reset_n && w_fetchWins;
  assign w_dataGnt   = i_Reset_n && i_DataReq && !w_fetchWins;

  assign o_FetchGnt       = w_fetchGnt;
  assign o_DataGnt        = w_dataGnt;
  assign o_MemWriteEnable = w_dataGnt && i_DataWrite;
  assign o_MemAddress     = w_fetchGnt ? i_FetchAddr :
                            w_dataGnt  ? i_DataAddr  : '0;
  assign o_MemDataIn      = (w_dataGnt && i_DataWrite) ? i_DataWdata : '0;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_rspState <= RSP_NONE;
      r_streak   <= '0;
    end else begin
      r_rspState <= nextRspState(w_fetchGnt, w_dataGnt, i_DataWrite);
      if (!i_FetchReq || w_fetchGnt)
        r_streak <= '0;
      else if (w_dataGnt && (r_streak != c_STREAK_MAX))
        r_streak <= r_streak + 1'b1;
    end
  end

  // Store responses carry no data, so only reads forward the memory output.
  assign o_FetchRspValid = (r_rspState == RSP_FETCH);
  assign o_FetchRspData  = (r_rspState == RSP_FETCH) ? i_MemDataOut : '0;
  assign o_DataRspValid  = (r_rspState == RSP_DATA_RD) || (r_rspState == RSP_DATA_WR);
  assign o_DataRspData   = (r_rspState == RSP_DATA_RD) ? i_MemDataOut : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter with a small memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchGnt;
  logic        fetchRspValid;
  logic [31:0] fetchRspData;
  logic        dataReq;
  logic        dataWrite;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic        dataGnt;
  logic        dataRspValid;
  logic [31:0] dataRspData;
  logic        memWe;
  logic [31:0] memAddress;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;

  logic [31:0] mem [0:255];

  int nChecks = 0;
  int nPass   = 0;

  mem_arbiter dut (
    .i_Clock         (clk),
    .i_Reset_n       (rstN),
    .i_FetchReq      (fetchReq),
    .i_FetchAddr     (fetchAddr),
    .o_FetchGnt      (fetchGnt),
    .o_FetchRspValid (fetchRspValid),
    .o_FetchRspData  (fetchRspData),
    .i_DataReq       (dataReq),
    .i_DataWrite     (dataWrite),
    .i_DataAddr      (dataAddr),
    .i_DataWdata     (dataWdata),
    .o_DataGnt       (dataGnt),
    .o_DataRspValid  (dataRspValid),
    .o_DataRspData   (dataRspData),
    .o_MemWriteEnable(memWe),
    .o_MemAddress    (memAddress),
    .o_MemDataIn     (memDataIn),
    .i_MemDataOut    (memDataOut)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: read data one cycle after the address.
  always @(posedge clk) begin
    if (memWe) mem[memAddress[9:2]] <= memDataIn;
    memDataOut <= mem[memAddress[9:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic stepTo();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] expGnt;
    logic [1:0] prevGnt;

    for (int i = 0; i < 256; i++) mem[i] <= '0;
    mem[4]  <= 32'hDEADBEEF;  // 0x10
    mem[16] <= 32'hA5A50001;  // 0x40
    mem[17] <= 32'h5A5A0002;  // 0x44
    mem[32] <= 32'h11110080;  // 0x80
    mem[33] <= 32'h22220084;  // 0x84
    memDataOut = '0;

    rstN = 1'b0;
    fetchReq = 1'b1; fetchAddr = 32'h10;
    dataReq = 1'b0; dataWrite = 1'b0; dataAddr = '0; dataWdata = '0;

    // Reset state: requests present but everything gated off.
    #2;
    chk("rst_gnt",  {fetchGnt, dataGnt}, 2'b00);
    chk("rst_rsp",  {fetchRspValid, dataRspValid, memWe}, 3'b000);
    chk("rst_port", {memAddress, memDataIn}, 64'h0);

    // Fetch in the very first cycle after reset release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("fetch_gnt",  {fetchGnt, dataGnt}, 2'b10);
    chk("fetch_addr", memAddress, 32'h10);
    stepTo();
    fetchReq = 1'b0;
    @(negedge clk);
    chk("fetch_rsp",  {fetchRspValid, dataRspValid}, 2'b10);
    chk("fetch_data", fetchRspData, 32'hDEADBEEF);
    chk("fetch_dz",   dataRspData, 32'h0);

    // Simultaneous fetch and load: data first, fetch next, responses in order.
    stepTo();
    fetchReq = 1'b1; fetchAddr = 32'h44;
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 32'h40;
    @(negedge clk);
    chk("both_gnt0",  {fetchGnt, dataGnt}, 2'b01);
    chk("both_addr0", memAddress, 32'h40);
    stepTo();
    dataReq = 1'b0;
    @(negedge clk);
    chk("both_gnt1",  {fetchGnt, dataGnt}, 2'b10);
    chk("both_addr1", memAddress, 32'h44);
    chk("both_rsp1",  {fetchRspValid, dataRspValid}, 2'b01);
    chk("both_data1", dataRspData, 32'hA5A50001);
    stepTo();
    fetchReq = 1'b0;
    @(negedge clk);
    chk("both_rsp2",  {fetchRspValid, dataRspValid}, 2'b10);
    chk("both_data2", fetchRspData, 32'h5A5A0002);

    // Continuous contention: D,D,D,D,F repeating.
    stepTo();
    fetchReq = 1'b1; fetchAddr = 32'h84;
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 32'h80;
    prevGnt = 2'b00;
    for (int i = 0; i < 10; i++) begin
      expGnt = ((i % 5) == 4) ? 2'b10 : 2'b01;
      @(negedge clk);
      chk($sformatf("stream_gnt%0d", i), {fetchGnt, dataGnt}, expGnt);
      chk($sformatf("stream_rsp%0d", i), {fetchRspValid, dataRspValid}, prevGnt);
      if (prevGnt == 2'b01) chk($sformatf("stream_dd%0d", i), dataRspData, 32'h11110080);
      if (prevGnt == 2'b10) chk($sformatf("stream_fd%0d", i), fetchRspData, 32'h22220084);
      prevGnt = expGnt;
      stepTo();
    end
    fetchReq = 1'b0; dataReq = 1'b0;
    @(negedge clk);
    chk("stream_last", {fetchRspValid, dataRspValid}, 2'b10);
    chk("stream_lastd", fetchRspData, 32'h22220084);

    // Store then load back.
    stepTo();
    dataReq = 1'b1; dataWrite = 1'b1; dataAddr = 32'h20; dataWdata = 32'h12345678;
    @(negedge clk);
    chk("st_gnt",  {dataGnt, memWe}, 2'b11);
    chk("st_port", {memAddress, memDataIn}, {32'h20, 32'h12345678});
    stepTo();
    dataReq = 1'b0; dataWrite = 1'b0; dataWdata = '0;
    @(negedge clk);
    chk("st_rsp",  {dataRspValid, memWe}, 2'b10);
    chk("st_data", dataRspData, 32'h0);
    stepTo();
    dataReq = 1'b1; dataAddr = 32'h20;
    @(negedge clk);
    chk("ld_gnt", {dataGnt, memWe}, 2'b10);
    stepTo();
    dataReq = 1'b0;
    @(negedge clk);
    chk("ld_rsp",  dataRspValid, 1'b1);
    chk("ld_data", dataRspData, 32'h12345678);

    // Reset while a load response is pending and the streak is saturated.
    stepTo();
    fetchReq = 1'b1; fetchAddr = 32'h84;
    dataReq = 1'b1; dataAddr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("pre_gnt%0d", i), {fetchGnt, dataGnt}, 2'b01);
      stepTo();
    end
    #1;
    rstN = 1'b0;
    #1;
    chk("arst_ctl",  {fetchGnt, dataGnt, fetchRspValid, dataRspValid, memWe}, 5'b0);
    chk("arst_port", {memAddress, memDataIn}, 64'h0);
    chk("arst_rspd", {fetchRspData, dataRspData}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("post_gnt", {fetchGnt, dataGnt}, 2'b01);
    chk("post_rsp", {fetchRspValid, dataRspValid}, 2'b00);
    stepTo();
    fetchReq = 1'b0; dataReq = 1'b0;
    @(negedge clk);
    chk("post_ld", {dataRspValid, dataRspData}, {1'b1, 32'h11110080});

    // Idle: nothing granted, nothing returned, port quiet.
    stepTo();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle_ctl%0d", i),
          {fetchGnt, dataGnt, fetchRspValid, dataRspValid, memWe}, 5'b0);
      chk($sformatf("idle_port%0d", i), {memAddress, memDataIn}, 64'h0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, memory data width in bits.
REQ-003 Parameter MAX_DATA_STREAK, default 4, consecutive data grants allowed while a fetch is pending (legal range 1..15).
REQ-004 i_Clock  in  1  sole clock; all state on rising edge.
REQ-005 i_Reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_FetchReq  in  1  instruction fetch request (read only).
REQ-007 i_FetchAddr  in  ADDR_W  fetch address.
REQ-008 o_FetchGnt  out  1  fetch request accepted this cycle.
REQ-009 o_FetchRspValid  out  1  fetch read data valid this cycle.
REQ-010 o_FetchRspData  out  DATA_W  fetch read data.
REQ-011 i_DataReq  in  1  load/store request.
REQ-012 i_DataWrite  in  1  1 = store, 0 = load.
REQ-013 i_DataAddr  in  ADDR_W  load/store address.
REQ-014 i_DataWdata  in  DATA_W  store data.
REQ-015 o_DataGnt  out  1  data request accepted this cycle.
REQ-016 o_DataRspValid  out  1  load data valid / store complete this cycle.
REQ-017 o_DataRspData  out  DATA_W  load data; zero for store responses.
REQ-018 o_MemWriteEnable  out  1  write strobe to the single-port synchronous memory.
REQ-019 o_MemAddress  out  ADDR_W  memory address.
REQ-020 o_MemDataIn  out  DATA_W  memory write data.
REQ-021 i_MemDataOut  in  DATA_W  memory read data, valid one cycle after address is presented.

Function
REQ-022 At most one grant per cycle; o_FetchGnt and o_DataGnt never both high.
REQ-023 Grants are combinational from requests and registered state; a granted request's address/data/write appear on the memory port in the same cycle.
REQ-024 Idle memory port: o_MemWriteEnable = 0, o_MemAddress = 0, o_MemDataIn = 0.
REQ-025 Priority: data over fetch, except when streak counter equals MAX_DATA_STREAK and i_FetchReq = 1, then fetch is granted.
REQ-026 Streak counter increments on each data grant while i_FetchReq = 1, saturates at MAX_DATA_STREAK, clears on fetch grant or any cycle with i_FetchReq = 0.
REQ-027 Requesters hold req/address/data stable until granted; the arbiter does not buffer ungranted requests.
REQ-028 Response FSM states: RSP_NONE, RSP_FETCH, RSP_DATA_RD, RSP_DATA_WR; next state set by the grant in the current cycle (none -> RSP_NONE).
REQ-029 RSP_FETCH: o_FetchRspValid = 1, o_FetchRspData = i_MemDataOut.
REQ-030 RSP_DATA_RD: o_DataRspValid = 1, o_DataRspData = i_MemDataOut.
REQ-031 RSP_DATA_WR: o_DataRspValid = 1, o_DataRspData = 0.
REQ-032 Response latency exactly 1 cycle after grant; back-to-back grants every cycle allowed, giving one response per cycle.
REQ-033 Response data outputs are 0 whenever the corresponding RspValid is 0.
REQ-034 Addresses pass through unmodified; no alignment checking.

Reset
REQ-035 i_Reset_n low asynchronously forces response FSM to RSP_NONE and streak counter to 0; all Gnt/RspValid outputs 0 while reset asserted.
REQ-036 A response pending when reset asserts is discarded; no RspValid after reset release for pre-reset grants.
REQ-037 First grant possible in the first cycle after i_Reset_n deasserts.

Structure
REQ-038 Response-state enum and MAX_DATA_STREAK default live in shared package cpu_pkg.
REQ-039 Single module; no sub-modules.

Verification
REQ-040 Fetch only, addr 0x10, memory returns 0xDEADBEEF -> o_FetchGnt cycle 0, o_FetchRspValid with 0xDEADBEEF cycle 1.
REQ-041 Fetch and load same cycle -> data granted; fetch granted next cycle; responses in grant order, one per cycle.
REQ-042 Continuous data and fetch requests, MAX_DATA_STREAK = 4 -> grant pattern D,D,D,D,F repeating.
REQ-043 Store addr 0x20 data 0x12345678 -> o_MemWriteEnable = 1, o_MemDataIn = 0x12345678 in grant cycle; o_DataRspValid with data 0 next cycle; later load of 0x20 returns 0x12345678.
REQ-044 Reset asserted in cycle between load grant and response -> no o_DataRspValid; all outputs 0 asynchronously.
REQ-045 No requests for 10 cycles -> no grants, no responses, memory port all zero.
